// File: rtl/json_feedback_rx.sv
// rtl/json_feedback_rx.sv - UART 8N1 receiver and flat-JSON T/L/R feedback parser
//
// Purpose: deserialises bytes from the base-board UART link and parses
// newline-terminated objects like {"T":1001,"L":0.5,"R":-164}. It publishes
// the T, L and R fields as signed values scaled by 100.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   uart_in    in   serial line, idle high
//   t_val      out  last T value x100, signed
//   l_val      out  last L value x100, signed
//   r_val      out  last R value x100, signed
//   field_mask out  {T,L,R} present in the last accepted message
//   msg_valid  out  one-cycle pulse when the value outputs update
//   msg_err    out  one-cycle pulse when a message or frame is discarded
module json_feedback_rx #(
    parameter int CLKS_PER_BIT = 50_000_000 / 115_200,
    parameter int BITS_N       = 8,
    parameter int VAL_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_in,
    output logic signed [VAL_W-1:0] t_val,
    output logic signed [VAL_W-1:0] l_val,
    output logic signed [VAL_W-1:0] r_val,
    output logic [2:0]              field_mask,
    output logic                    msg_valid,
    output logic                    msg_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W = $clog2(BITS_N + 1);
    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int ACC_W = VAL_W + 8;

    localparam logic [63:0]      MAXV64  = (64'd1 << (VAL_W - 1)) - 64'd1;
    localparam logic [ACC_W-1:0] MAXV    = ACC_W'(MAXV64);
    // Largest integer part whose x100 still fits; anything above is pinned
    // one past it so the final clamp always fires.
    localparam logic [ACC_W-1:0] INT_LIM = ACC_W'(MAXV64 / 64'd100);
    localparam logic [ACC_W-1:0] INT_SAT = INT_LIM + ACC_W'(1);

    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_QUOTE  = 8'h22;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_MINUS  = 8'h2D;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [BITS_N-1:0] shift_q, shift_d;
    logic              sync1_q, sync2_q, prev_q;
    logic              byte_stb, frame_err;
    logic [7:0]        rx_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            sync1_q    <= uart_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_stb   = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A start bit that has gone high again was a glitch.
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[BITS_N-1:1]};
                    if (bit_q == BIT_W'(BITS_N - 1)) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    // Back to idle mid stop bit so the next start edge is caught.
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    byte_stb   = sync2_q;
                    frame_err  = !sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign rx_byte = 8'(shift_q);

    // ---------------- JSON parser ----------------
    typedef enum logic [3:0] {
        P_IDLE, P_KQ1, P_KEY, P_KQ2, P_COLON, P_VSTART, P_VINT, P_VFRAC, P_NL, P_ERR
    } p_state_e;

    p_state_e                p_state_q, p_state_d;
    logic [ACC_W-1:0]        int_q, int_d;
    logic [6:0]              frac_q, frac_d;
    logic [1:0]              fdig_q, fdig_d;
    logic                    neg_q, neg_d;
    logic [7:0]              key_q, key_d;
    logic signed [VAL_W-1:0] t_s_q, t_s_d, l_s_q, l_s_d, r_s_q, r_s_d;
    logic [2:0]              mask_s_q, mask_s_d;
    logic                    valid_d, perr, commit, clear_val, clear_msg;
    logic                    is_dig;
    logic [3:0]              dig_v;
    logic [ACC_W-1:0]        int_mul, int_acc, mag, mag_c;
    logic [VAL_W-1:0]        commit_val;

    assign is_dig  = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    assign dig_v   = rx_byte[3:0];
    assign int_mul = (int_q * ACC_W'(10)) + ACC_W'(dig_v);
    assign int_acc = (int_mul > INT_LIM) ? INT_SAT : int_mul;
    assign mag     = (int_q * ACC_W'(100)) + ACC_W'(frac_q);
    assign mag_c   = (mag > MAXV) ? MAXV : mag;
    assign commit_val = VAL_W'(neg_q ? (~mag_c + ACC_W'(1)) : mag_c);

    always_comb begin
        p_state_d = p_state_q;
        int_d     = int_q;
        frac_d    = frac_q;
        fdig_d    = fdig_q;
        neg_d     = neg_q;
        key_d     = key_q;
        t_s_d     = t_s_q;
        l_s_d     = l_s_q;
        r_s_d     = r_s_q;
        mask_s_d  = mask_s_q;
        valid_d   = 1'b0;
        perr      = 1'b0;
        commit    = 1'b0;
        clear_val = 1'b0;
        clear_msg = 1'b0;

        if (frame_err) begin
            p_state_d = P_ERR;
        end else if (byte_stb && !(rx_byte == CH_SPACE && p_state_q != P_KEY)) begin
            case (p_state_q)
                P_IDLE: begin
                    if (rx_byte == CH_LBRACE) begin
                        clear_msg = 1'b1;
                        p_state_d = P_KQ1;
                    end
                end
                P_KQ1: begin
                    if (rx_byte == CH_QUOTE) p_state_d = P_KEY;
                    else perr = 1'b1;
                end
                P_KEY: begin
                    key_d     = rx_byte;
                    p_state_d = P_KQ2;
                end
                P_KQ2: begin
                    if (rx_byte == CH_QUOTE) p_state_d = P_COLON;
                    else perr = 1'b1;
                end
                P_COLON: begin
                    if (rx_byte == CH_COLON) p_state_d = P_VSTART;
                    else perr = 1'b1;
                end
                P_VSTART: begin
                    if (rx_byte == CH_MINUS) begin
                        neg_d = 1'b1;
                    end else if (is_dig) begin
                        int_d     = int_acc;
                        p_state_d = P_VINT;
                    end else begin
                        perr = 1'b1;
                    end
                end
                P_VINT, P_VFRAC: begin
                    if (is_dig) begin
                        if (p_state_q == P_VINT) begin
                            int_d = int_acc;
                        end else if (fdig_q == 2'd0) begin
                            frac_d = 7'(dig_v) * 7'd10;
                            fdig_d = 2'd1;
                        end else if (fdig_q == 2'd1) begin
                            frac_d = frac_q + 7'(dig_v);
                            fdig_d = 2'd2;
                        end
                    end else if (rx_byte == CH_DOT && p_state_q == P_VINT) begin
                        p_state_d = P_VFRAC;
                    end else if (rx_byte == CH_COMMA) begin
                        commit    = 1'b1;
                        p_state_d = P_KQ1;
                    end else if (rx_byte == CH_RBRACE) begin
                        commit    = 1'b1;
                        p_state_d = P_NL;
                    end else begin
                        perr = 1'b1;
                    end
                end
                P_NL: begin
                    if (rx_byte == CH_LF) begin
                        valid_d   = 1'b1;
                        p_state_d = P_IDLE;
                    end else if (rx_byte != CH_CR) begin
                        perr = 1'b1;
                    end
                end
                P_ERR: begin
                    if (rx_byte == CH_LF) begin
                        p_state_d = P_IDLE;
                    end else if (rx_byte == CH_LBRACE) begin
                        clear_msg = 1'b1;
                        p_state_d = P_KQ1;
                    end
                end
                default: p_state_d = P_IDLE;
            endcase
        end

        if (perr) p_state_d = P_ERR;

        // Unknown keys fall through here without touching staging.
        if (commit) begin
            clear_val = 1'b1;
            case (key_q)
                8'h54: begin t_s_d = commit_val; mask_s_d[2] = 1'b1; end
                8'h4C: begin l_s_d = commit_val; mask_s_d[1] = 1'b1; end
                8'h52: begin r_s_d = commit_val; mask_s_d[0] = 1'b1; end
                default: ;
            endcase
        end

        if (clear_msg) begin
            clear_val = 1'b1;
            mask_s_d  = 3'b000;
        end

        if (clear_val) begin
            int_d  = '0;
            frac_d = '0;
            fdig_d = '0;
            neg_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_state_q  <= P_IDLE;
            int_q      <= '0;
            frac_q     <= '0;
            fdig_q     <= '0;
            neg_q      <= 1'b0;
            key_q      <= '0;
            t_s_q      <= '0;
            l_s_q      <= '0;
            r_s_q      <= '0;
            mask_s_q   <= '0;
            t_val      <= '0;
            l_val      <= '0;
            r_val      <= '0;
            field_mask <= '0;
            msg_valid  <= 1'b0;
            msg_err    <= 1'b0;
        end else begin
            p_state_q <= p_state_d;
            int_q     <= int_d;
            frac_q    <= frac_d;
            fdig_q    <= fdig_d;
            neg_q     <= neg_d;
            key_q     <= key_d;
            t_s_q     <= t_s_d;
            l_s_q     <= l_s_d;
            r_s_q     <= r_s_d;
            mask_s_q  <= mask_s_d;
            msg_valid <= valid_d;
            msg_err   <= perr | frame_err;
            if (valid_d) begin
                // Absent fields keep their last published value.
                field_mask <= mask_s_q;
                if (mask_s_q[2]) t_val <= t_s_q;
                if (mask_s_q[1]) l_val <= l_s_q;
                if (mask_s_q[0]) r_val <= r_s_q;
            end
        end
    end

endmodule
